// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared definitions for the traffic conflict monitor.
// Holds the lamp encodings ({red,yellow,green}), the fault cause codes,
// the monitor state type and two small lamp helpers.
package traffic_conflict_monitor_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ENC      = 2'd1;
  localparam logic [1:0] FC_CONFLICT = 2'd2;
  localparam logic [1:0] FC_SEQ      = 2'd3;

  typedef enum logic [1:0] {
    ST_RECOVER = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  function automatic logic lamp_legal(input logic [2:0] v);
    return (v == RED) || (v == YEL) || (v == GRN);
  endfunction

  // Next aspect in the only permitted cycle R -> G -> Y -> R.
  function automatic logic [2:0] lamp_advance(input logic [2:0] v);
    case (v)
      RED:     return GRN;
      GRN:     return YEL;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp bus between controller, monitor and field hardware.
//   light_M1/M2/MT/S : lamp commands from the controller
//   clr_fault        : operator request to leave the fault state
//   out_M1/M2/MT/S   : lamp drive towards the field
//   fault, fault_code: fault indication and latched cause
// master = controller/operator side, slave = monitor side.
interface traffic_conflict_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic       clr_fault;
  logic [2:0] out_M1;
  logic [2:0] out_M2;
  logic [2:0] out_MT;
  logic [2:0] out_S;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output light_M1, light_M2, light_MT, light_S, clr_fault,
    input  out_M1, out_M2, out_MT, out_S, fault, fault_code
  );

  modport slave (
    input  light_M1, light_M2, light_MT, light_S, clr_fault,
    output out_M1, out_M2, out_MT, out_S, fault, fault_code
  );
endinterface

// File: rtl/traffic_conflict_monitor_lamp_check.sv
// Per-lamp checker.
//   cur     : lamp command this cycle
//   prev    : registered lamp command of the previous cycle
//   enc_err : cur is not a single-lamp encoding
//   seq_err : cur is not a hold or the next step of R -> G -> Y -> R
// A step from or to an illegal code is left to the encoding check, so a
// one-cycle glitch does not also count as a sequence error when it ends.
module lamp_check
  import traffic_conflict_monitor_pkg::*;
(
  input  logic [2:0] cur,
  input  logic [2:0] prev,
  output logic       enc_err,
  output logic       seq_err
);

  logic step_ok;

  assign enc_err = !lamp_legal(cur);
  assign step_ok = (cur == prev) || (cur == lamp_advance(prev));
  assign seq_err = lamp_legal(cur) && lamp_legal(prev) && !step_ok;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Conflict monitor sitting between a traffic light controller and the
// field lamps. After reset or a fault clear it drives solid red for
// RECOVER_CYC cycles, then passes lamp commands through with one cycle of
// latency. Encoding, conflicting-green and sequence violations persisting
// for FAULT_FILT cycles latch a fault: all lamps then flash red with a
// half-period of FLASH_HALF cycles until the operator clears it on a
// clean cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lamp bus, slave side
module traffic_conflict_monitor
  import traffic_conflict_monitor_pkg::*;
#(
  parameter int FAULT_FILT  = 2,
  parameter int FLASH_HALF  = 5,
  parameter int RECOVER_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_conflict_monitor_if.slave  bus
);

  localparam logic [3:0] FILT_MAX   = 4'(FAULT_FILT);
  localparam logic [7:0] RCV_LAST   = 8'(RECOVER_CYC - 1);
  localparam logic [7:0] FLASH_H    = 8'(FLASH_HALF);
  localparam logic [7:0] FLASH_LAST = 8'(2 * FLASH_HALF - 1);

  // Lamp index: 0 = M1, 1 = M2, 2 = MT, 3 = S.
  logic [3:0][2:0] cur;
  logic [3:0][2:0] prev_p1, out_p1, out_n;
  logic [3:0]      enc_err, seq_err, grn;
  logic            conflict, viol;
  logic [1:0]      cause, code, code_n;
  logic [3:0]      filt, filt_n, filt_inc;
  logic [7:0]      rcnt, rcnt_n, fcnt, fcnt_n;
  state_t          state, state_n;

  assign cur = {bus.light_S, bus.light_MT, bus.light_M2, bus.light_M1};

  for (genvar i = 0; i < 4; i++) begin : g_lamp
    lamp_check u_lamp_check (
      .cur     (cur[i]),
      .prev    (prev_p1[i]),
      .enc_err (enc_err[i]),
      .seq_err (seq_err[i])
    );
    assign grn[i] = (cur[i] == GRN);
  end

  assign conflict = (grn[3] && (grn[0] || grn[1] || grn[2])) || (grn[2] && grn[1]);
  assign viol     = (|enc_err) || conflict || (|seq_err);
  assign cause    = (|enc_err) ? FC_ENC :
                    conflict   ? FC_CONFLICT :
                    (|seq_err) ? FC_SEQ : FC_NONE;
  assign filt_inc = (filt == FILT_MAX) ? filt : filt + 4'd1;

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    filt_n  = '0;
    fcnt_n  = fcnt;
    code_n  = code;
    out_n   = {4{RED}};
    case (state)
      ST_RECOVER: begin
        if (rcnt == RCV_LAST) begin
          state_n = ST_MONITOR;
          rcnt_n  = '0;
          out_n   = cur;
        end else begin
          rcnt_n = rcnt + 8'd1;
        end
      end
      ST_MONITOR: begin
        filt_n = viol ? filt_inc : 4'd0;
        if (viol && (filt_inc == FILT_MAX)) begin
          state_n = ST_FAULT;
          code_n  = cause;
          fcnt_n  = '0;
          filt_n  = '0;
        end else begin
          out_n = cur;
        end
      end
      ST_FAULT: begin
        if (bus.clr_fault && !viol) begin
          state_n = ST_RECOVER;
          rcnt_n  = '0;
          fcnt_n  = '0;
          code_n  = FC_NONE;
        end else begin
          fcnt_n = (fcnt == FLASH_LAST) ? 8'd0 : fcnt + 8'd1;
          out_n  = (fcnt_n < FLASH_H) ? {4{RED}} : {4{OFF}};
        end
      end
      default: state_n = ST_RECOVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RECOVER;
      rcnt    <= '0;
      filt    <= '0;
      fcnt    <= '0;
      code    <= FC_NONE;
      prev_p1 <= {4{RED}};
      out_p1  <= {4{RED}};
    end else begin
      state   <= state_n;
      rcnt    <= rcnt_n;
      filt    <= filt_n;
      fcnt    <= fcnt_n;
      code    <= code_n;
      prev_p1 <= cur;
      out_p1  <= out_n;
    end
  end

  assign bus.out_M1     = out_p1[0];
  assign bus.out_M2     = out_p1[1];
  assign bus.out_MT     = out_p1[2];
  assign bus.out_S      = out_p1[3];
  assign bus.fault      = (state == ST_FAULT);
  assign bus.fault_code = code;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: one instance with default
// parameters and one with FAULT_FILT=1, both fed the same lamp commands
// and compared every cycle against a behavioural model, plus directed
// checks of the documented scenarios.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam int RCV = 8;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [2:0] lin [4];

  int n_chk = 0;
  int n_fail = 0;

  traffic_conflict_monitor_if if0 ();
  traffic_conflict_monitor_if if1 ();

  assign if0.light_M1 = lin[0];
  assign if0.light_M2 = lin[1];
  assign if0.light_MT = lin[2];
  assign if0.light_S  = lin[3];
  assign if0.clr_fault = clr;
  assign if1.light_M1 = lin[0];
  assign if1.light_M2 = lin[1];
  assign if1.light_MT = lin[2];
  assign if1.light_S  = lin[3];
  assign if1.clr_fault = clr;

  traffic_conflict_monitor dut0 (.clk(clk), .rst(rst), .bus(if0));
  traffic_conflict_monitor #(.FAULT_FILT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 all-red recovery, 1 pass-through, 2 flashing fault
  int mode [2];
  int rc [2];
  int fl [2];
  int filt [2];
  int code [2];
  logic [2:0] eout [2][4];
  logic [2:0] mprev [4];

  function automatic int filt_limit(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit legal(input logic [2:0] v);
    return (v == RED) || (v == YEL) || (v == GRN);
  endfunction

  function automatic logic [2:0] successor(input logic [2:0] v);
    case (v)
      RED:     return GRN;
      GRN:     return YEL;
      default: return RED;
    endcase
  endfunction

  function automatic int model_cause();
    bit enc = 0, seq = 0, conf;
    for (int i = 0; i < 4; i++) begin
      if (!legal(lin[i])) enc = 1;
      else if (legal(mprev[i]) && lin[i] != mprev[i] && lin[i] != successor(mprev[i])) seq = 1;
    end
    conf = (lin[3] == GRN && (lin[0] == GRN || lin[1] == GRN || lin[2] == GRN)) ||
           (lin[2] == GRN && lin[1] == GRN);
    if (enc) return 1;
    if (conf) return 2;
    if (seq) return 3;
    return 0;
  endfunction

  task automatic set_eout(input int k, input logic [2:0] v);
    for (int i = 0; i < 4; i++) eout[k][i] = v;
  endtask

  task automatic pass_eout(input int k);
    for (int i = 0; i < 4; i++) eout[k][i] = lin[i];
  endtask

  task automatic model_step();
    int cz;
    cz = model_cause();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mode[k] = 0; rc[k] = 0; fl[k] = 0; filt[k] = 0; code[k] = 0;
        set_eout(k, RED);
      end else if (mode[k] == 0) begin
        rc[k]++;
        if (rc[k] == RCV) begin
          mode[k] = 1; rc[k] = 0; pass_eout(k);
        end else set_eout(k, RED);
      end else if (mode[k] == 1) begin
        if (cz != 0) filt[k] = (filt[k] + 1 > filt_limit(k)) ? filt_limit(k) : filt[k] + 1;
        else filt[k] = 0;
        if (filt[k] == filt_limit(k)) begin
          mode[k] = 2; code[k] = cz; fl[k] = 0; filt[k] = 0; set_eout(k, RED);
        end else pass_eout(k);
      end else begin
        if (clr && cz == 0) begin
          mode[k] = 0; rc[k] = 0; code[k] = 0; set_eout(k, RED);
        end else begin
          fl[k] = (fl[k] + 1) % (2 * HALF);
          set_eout(k, (fl[k] < HALF) ? RED : OFF);
        end
      end
    end
    for (int i = 0; i < 4; i++) mprev[i] = rst ? RED : lin[i];
  endtask

  task automatic compare_all();
    chk("dut0_out", {if0.out_S, if0.out_MT, if0.out_M2, if0.out_M1},
        {eout[0][3], eout[0][2], eout[0][1], eout[0][0]});
    chk("dut0_fault", if0.fault, (mode[0] == 2));
    chk("dut0_code", if0.fault_code, code[0]);
    chk("dut1_out", {if1.out_S, if1.out_MT, if1.out_M2, if1.out_M1},
        {eout[1][3], eout[1][2], eout[1][1], eout[1][0]});
    chk("dut1_fault", if1.fault, (mode[1] == 2));
    chk("dut1_code", if1.fault_code, code[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    bit seen;
    rst = 1'b1; clr = 1'b0;
    for (int i = 0; i < 4; i++) lin[i] = RED;
    for (int i = 0; i < 4; i++) mprev[i] = RED;
    cycle();
    chk("rst_out", {if0.out_S, if0.out_MT, if0.out_M2, if0.out_M1}, {4{RED}});
    chk("rst_fault", if0.fault, 1'b0);
    chk("rst_code", if0.fault_code, 2'd0);

    // Power-up recovery then pass-through
    rst = 1'b0; lin[0] = GRN; lin[1] = GRN;
    for (int i = 1; i < RCV; i++) begin
      cycle();
      chk("recover_red", if0.out_M1, RED);
    end
    cycle();
    chk("follow_m1", if0.out_M1, GRN);
    chk("follow_nofault", if0.fault, 1'b0);
    cycle();

    // S green against M1 green for two cycles
    lin[3] = GRN;
    cycle();
    chk("window_pass_s", if0.out_S, GRN);
    chk("window_nofault", if0.fault, 1'b0);
    chk("filt1_fast_fault", if1.fault, 1'b1);
    cycle();
    chk("conflict_fault", if0.fault, 1'b1);
    chk("conflict_code", if0.fault_code, 2'd2);
    chk("flash_entry", if0.out_M1, RED);
    for (int i = 1; i < 15; i++) begin
      cycle();
      chk("flash_phase", if0.out_M1, ((i % 10) < 5) ? RED : OFF);
      chk("flash_code_hold", if0.fault_code, 2'd2);
    end

    // Clear refused while conflict persists, accepted once gone
    clr = 1'b1;
    cycle();
    chk("clr_blocked", if0.fault, 1'b1);
    lin[3] = YEL;
    cycle();
    chk("clr_exit", if0.fault, 1'b0);
    chk("clr_code", if0.fault_code, 2'd0);
    chk("clr_red", if0.out_S, RED);
    clr = 1'b0; lin[3] = RED;
    for (int i = 1; i < RCV; i++) begin
      cycle();
      chk("clr_recover_red", if0.out_M1, RED);
    end
    cycle();
    chk("clr_back_monitor", if0.out_M1, GRN);

    // One-cycle illegal encoding on M2
    lin[1] = 3'b011;
    cycle();
    chk("glitch_pass", if0.out_M2, 3'b011);
    chk("glitch_nofault", if0.fault, 1'b0);
    chk("filt1_enc_code", if1.fault_code, 2'd1);
    lin[1] = GRN;
    cycle();
    chk("glitch_end_nofault", if0.fault, 1'b0);
    chk("glitch_end_out", if0.out_M2, GRN);
    cycle();
    chk("glitch_filter_clear", if0.fault, 1'b0);
    clr = 1'b1;
    cycle();
    chk("clr_outside_fault", if0.fault, 1'b0);
    chk("filt1_cleared", if1.fault, 1'b0);
    clr = 1'b0;
    run(RCV + 1);

    // Green straight to red on M1
    lin[0] = RED;
    cycle();
    chk("seq_code_filt1", if1.fault_code, 2'd3);
    chk("seq_fault_filt1", if1.fault, 1'b1);
    chk("seq_window_filt2", if0.fault, 1'b0);
    cycle();
    chk("seq_hold_legal", if0.fault, 1'b0);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    run(RCV + 1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(99);
        if (r < 70) lin[i] = lin[i];
        else if (r < 88) lin[i] = successor(lin[i]);
        else if (r < 94) lin[i] = 3'($urandom);
        else begin
          r = $urandom_range(2);
          lin[i] = (r == 0) ? RED : (r == 1) ? YEL : GRN;
        end
      end
      clr = ($urandom_range(7) == 0);
      rst = ($urandom_range(299) == 0);
      cycle();
    end

    // Reset during the dark half of the flash
    rst = 1'b1; clr = 1'b0;
    for (int i = 0; i < 4; i++) lin[i] = RED;
    cycle();
    rst = 1'b0;
    run(RCV + 1);
    lin[0] = GRN;
    cycle();
    lin[3] = GRN;
    run(2);
    chk("pre_rst_fault", if0.fault, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      if (if0.out_M1 == OFF) seen = 1'b1;
    end
    chk("flash_off_seen", seen, 1'b1);
    rst = 1'b1;
    cycle();
    chk("rst_flash_out", {if0.out_S, if0.out_MT, if0.out_M2, if0.out_M1}, {4{RED}});
    chk("rst_flash_fault", if0.fault, 1'b0);
    chk("rst_flash_code", if0.fault_code, 2'd0);
    rst = 1'b0;
    cycle();
    chk("rst_recover_red", if0.out_M1, RED);
    run(RCV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
